// File: rtl/pacman_death_seq.sv
// Pac-Man collision/death sequencer: ghost hit detection, spin animation, lives, respawn, game over.
// Optional post-respawn immunity is compiled in with `define INVULN_EN.
module pacman_death_seq #(
   parameter int unsigned NUM_GHOSTS     = 4,
   parameter int unsigned COORD_W        = 7,
   parameter int unsigned SPIN_FRAMES    = 8,
   parameter int unsigned RESPAWN_FRAMES = 4,
   parameter int unsigned LIVES_INIT     = 3,
   parameter int unsigned LIVES_W        = 3,
   parameter int unsigned INVULN_FRAMES  = 16
) (
   input  logic                             animation_clk,
   input  logic                             reset,
   input  logic [COORD_W-1:0]               pac_x,
   input  logic [COORD_W-1:0]               pac_y,
   input  logic [3:0]                       pac_dir_in,
   input  logic [NUM_GHOSTS*COORD_W-1:0]    ghost_x,
   input  logic [NUM_GHOSTS*COORD_W-1:0]    ghost_y,
   input  logic [NUM_GHOSTS-1:0]            ghost_eatable,
   output logic [3:0]                       pacman_cur_dir,
   output logic                             pacman_dead,
   output logic [LIVES_W-1:0]               lives,
   output logic [NUM_GHOSTS-1:0]            ghost_eaten,
   output logic                             respawn,
   output logic                             game_over,
   output logic                             invulnerable
);

   localparam int unsigned MAX_A      = (SPIN_FRAMES > RESPAWN_FRAMES) ? SPIN_FRAMES : RESPAWN_FRAMES;
   localparam int unsigned MAX_FRAMES = (MAX_A > INVULN_FRAMES) ? MAX_A : INVULN_FRAMES;
   localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

   typedef enum logic [1:0] {
      ST_ALIVE,
      ST_SPIN,
      ST_RESPAWN,
      ST_OVER
   } state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [3:0]             dir_q;
   logic                   dead_q;
   logic [LIVES_W-1:0]     lives_q;
   logic [NUM_GHOSTS-1:0]  eaten_q;
   logic                   respawn_q;
   logic                   over_q;
   logic                   inv_q;

   logic [NUM_GHOSTS-1:0]  hit_c;
   logic [NUM_GHOSTS-1:0]  eat_c;
   logic                   lethal_c;
   logic                   kill_c;

   // Exact tile match against every ghost channel
   always_comb begin
      hit_c = '0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
         hit_c[i] = (pac_x == ghost_x[i*COORD_W +: COORD_W]) &&
                    (pac_y == ghost_y[i*COORD_W +: COORD_W]);
      end
   end

   assign eat_c    = hit_c & ghost_eatable;
   assign lethal_c = |(hit_c & ~ghost_eatable);

`ifdef INVULN_EN
   assign kill_c = lethal_c && !inv_q;
`else
   assign kill_c = lethal_c;
`endif

   function automatic logic [3:0] spin_dir(input logic [1:0] phase);
      case (phase)
         2'd0:    spin_dir = 4'b0001;
         2'd1:    spin_dir = 4'b0100;
         2'd2:    spin_dir = 4'b0010;
         default: spin_dir = 4'b1000;
      endcase
   endfunction

   always_ff @(posedge animation_clk) begin
      if (reset) begin
         state_q   <= ST_ALIVE;
         cnt_q     <= '0;
         dir_q     <= 4'b0001;
         dead_q    <= 1'b0;
         lives_q   <= LIVES_W'(LIVES_INIT);
         eaten_q   <= '0;
         respawn_q <= 1'b0;
         over_q    <= 1'b0;
         inv_q     <= 1'b0;
      end else begin
         eaten_q   <= '0;
         respawn_q <= 1'b0;
         case (state_q)
            ST_ALIVE: begin
               dir_q <= pac_dir_in;
`ifdef INVULN_EN
               // Immunity window counts down in ALIVE only
               if (inv_q) begin
                  if (cnt_q == CNT_W'(INVULN_FRAMES - 1)) begin
                     inv_q <= 1'b0;
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
`endif
               if (kill_c) begin
                  state_q <= ST_SPIN;
                  cnt_q   <= '0;
                  dead_q  <= 1'b1;
                  lives_q <= (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
               end else begin
                  eaten_q <= eat_c;
               end
            end
            ST_SPIN: begin
               dir_q <= spin_dir(2'(cnt_q));
               if (cnt_q == CNT_W'(SPIN_FRAMES - 1)) begin
                  cnt_q <= '0;
                  if (lives_q == '0) begin
                     state_q <= ST_OVER;
                     over_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RESPAWN;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RESPAWN: begin
               dir_q <= 4'b0001;
               if (cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
                  cnt_q     <= '0;
                  state_q   <= ST_ALIVE;
                  dead_q    <= 1'b0;
                  respawn_q <= 1'b1;
`ifdef INVULN_EN
                  inv_q     <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_OVER: begin
               dir_q   <= 4'b0001;
               dead_q  <= 1'b1;
               over_q  <= 1'b1;
               lives_q <= '0;
            end
            default: begin
               state_q <= ST_ALIVE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign pacman_cur_dir = dir_q;
   assign pacman_dead    = dead_q;
   assign lives          = lives_q;
   assign ghost_eaten    = eaten_q;
   assign respawn        = respawn_q;
   assign game_over      = over_q;
`ifdef INVULN_EN
   assign invulnerable   = inv_q;
`else
   assign invulnerable   = 1'b0;
   logic unused_inv;
   assign unused_inv     = inv_q;
`endif

endmodule
